// File: rtl/cb_pkg.sv
// Shared widths and entry layout for the FU-to-CDB completion buffer.
package cb_pkg;

  localparam int CB_DATA_W = 64;
  localparam int CB_TAG_W  = 6;
  localparam int CB_ITAG_W = 9;
  localparam int CB_NEED_W = 2;

  // Default-width view of one queued instruction result.
  typedef struct packed {
    logic [CB_DATA_W-1:0] out1;
    logic [CB_DATA_W-1:0] out2;
    logic [CB_ITAG_W-1:0] tag;
    logic                 dual;
  } cb_entry_t;

endpackage

// File: rtl/completion_buffer_q_if.sv
// FU push side and CDB request/grant/drive side of the completion buffer.
interface completion_buffer_q_if
  import cb_pkg::*;
#(
  parameter int DATA_W = CB_DATA_W,
  parameter int TAG_W  = CB_TAG_W,
  parameter int ITAG_W = CB_ITAG_W,
  parameter int NBUS   = 4
);
  logic                   fu_valid;
  logic                   fu_dual;
  logic [DATA_W-1:0]      fu_output1;
  logic [DATA_W-1:0]      fu_output2;
  logic [ITAG_W-1:0]      inst_tag;
  logic                   fu_ready;
  logic                   bus_request;
  logic [CB_NEED_W-1:0]   bus_need;
  logic [NBUS-1:0]        bus_grant;
  logic [NBUS-1:0]        bus_en;
  logic [NBUS-1:0]        bus_sec;
  logic [TAG_W*NBUS-1:0]  bus_tag;
  logic [DATA_W*NBUS-1:0] bus_data;

  modport slave (
    input  fu_valid, fu_dual, fu_output1, fu_output2, inst_tag, bus_grant,
    output fu_ready, bus_request, bus_need, bus_en, bus_sec, bus_tag, bus_data
  );

  modport master (
    output fu_valid, fu_dual, fu_output1, fu_output2, inst_tag, bus_grant,
    input  fu_ready, bus_request, bus_need, bus_en, bus_sec, bus_tag, bus_data
  );
endinterface

// File: rtl/cb_pick2.sv
// Picks the two lowest granted channels (one-hot) and a popcount saturated at 2.
module cb_pick2 #(
  parameter int NBUS = 4
) (
  input  logic [NBUS-1:0] grant,
  output logic [NBUS-1:0] c0,
  output logic [NBUS-1:0] c1,
  output logic [1:0]      cnt
);
  logic [NBUS-1:0] rest;

  // x & -x isolates the lowest set bit.
  assign c0   = grant & (~grant + NBUS'(1));
  assign rest = grant & ~c0;
  assign c1   = rest & (~rest + NBUS'(1));
  assign cnt  = (c1 != '0) ? 2'd2 : ((c0 != '0) ? 2'd1 : 2'd0);
endmodule

// File: rtl/completion_buffer_q.sv
// DEPTH-entry FIFO of FU results feeding up to two CDB channels per instruction.
module completion_buffer_q
  import cb_pkg::*;
#(
  parameter int DATA_W = CB_DATA_W,
  parameter int TAG_W  = CB_TAG_W,
  parameter int ITAG_W = CB_ITAG_W,
  parameter int DEPTH  = 4,
  parameter int NBUS   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     kill,
  completion_buffer_q_if.slave     cb,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] out2;
    logic [ITAG_W-1:0] tag;
    logic              dual;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            empty, full, push, pop;
  logic [NBUS-1:0] c0, c1;
  logic [1:0]      grant_cnt;

  cb_pick2 #(.NBUS(NBUS)) u_pick (
    .grant (cb.bus_grant),
    .c0    (c0),
    .c1    (c1),
    .cnt   (grant_cnt)
  );

  assign head  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;

  assign cb.fu_ready    = !full;
  assign cb.bus_request = !empty;
  assign cb.bus_need    = empty ? 2'd0 : (head.dual ? 2'd2 : 2'd1);

  // A partial grant is never used: the head leaves only when all its channels arrive.
  assign pop  = !kill && !empty && (grant_cnt >= cb.bus_need);
  assign push = cb.fu_valid && !full && !kill;

  always_comb begin
    cb.bus_en  = '0;
    cb.bus_sec = '0;
    if (pop) begin
      cb.bus_en  = c0 | (head.dual ? c1 : '0);
      cb.bus_sec = head.dual ? c1 : '0;
    end
  end

  for (genvar gi = 0; gi < NBUS; gi++) begin : g_chan
    assign cb.bus_tag[gi*TAG_W +: TAG_W] =
      cb.bus_en[gi] ? head.tag[TAG_W-1:0] : '0;
    assign cb.bus_data[gi*DATA_W +: DATA_W] =
      !cb.bus_en[gi] ? '0 : (cb.bus_sec[gi] ? head.out2 : head.out1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {cb.fu_output1, cb.fu_output2, cb.inst_tag, cb.fu_dual};
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (kill) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end
endmodule

// File: tb/tb_completion_buffer_q.sv
// Scenario bench for completion_buffer_q with an expected-result queue.
module tb_completion_buffer_q;
  logic       clk;
  logic       rst;
  logic       kill;
  logic [2:0] count;

  completion_buffer_q_if #(.DATA_W(64), .TAG_W(6), .ITAG_W(9), .NBUS(4)) cb_if ();

  completion_buffer_q #(.DATA_W(64), .TAG_W(6), .ITAG_W(9), .DEPTH(4), .NBUS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .kill  (kill),
    .cb    (cb_if.slave),
    .count (count)
  );

  typedef struct {
    logic [5:0]  tag;
    logic        dual;
    logic [63:0] o1;
    logic [63:0] o2;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           n_cmp;
  int           n_fail;
  logic [3:0]   e_en, e_sec;
  logic [23:0]  e_tag;
  logic [255:0] e_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] f_en(input logic [3:0] g, input logic dual, input logic want_sec);
    int n = 0;
    logic [3:0] en = '0;
    logic [3:0] sec = '0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        if (n == 0) en[i] = 1'b1;
        else if (n == 1 && dual) begin
          en[i]  = 1'b1;
          sec[i] = 1'b1;
        end
        n++;
      end
    end
    if (n < (dual ? 2 : 1)) begin
      en  = '0;
      sec = '0;
    end
    return want_sec ? sec : en;
  endfunction

  function automatic logic [23:0] f_tag(input logic [3:0] en, input logic [5:0] tag);
    logic [23:0] v = '0;
    for (int i = 0; i < 4; i++) if (en[i]) v[i*6 +: 6] = tag;
    return v;
  endfunction

  function automatic logic [255:0] f_data(input logic [3:0] en, input logic [3:0] sec,
                                          input logic [63:0] o1, input logic [63:0] o2);
    logic [255:0] v = '0;
    for (int i = 0; i < 4; i++) if (en[i]) v[i*64 +: 64] = sec[i] ? o2 : o1;
    return v;
  endfunction

  task automatic idle_inputs();
    cb_if.fu_valid   = 1'b0;
    cb_if.fu_dual    = 1'b0;
    cb_if.fu_output1 = '0;
    cb_if.fu_output2 = '0;
    cb_if.inst_tag   = '0;
    cb_if.bus_grant  = '0;
    kill             = 1'b0;
  endtask

  task automatic drive_push(input logic [8:0] tag, input logic dual,
                            input logic [63:0] o1, input logic [63:0] o2);
    cb_if.fu_valid   = 1'b1;
    cb_if.fu_dual    = dual;
    cb_if.fu_output1 = o1;
    cb_if.fu_output2 = o2;
    cb_if.inst_tag   = tag;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_push(9'h001, 1'b0, 64'h11, 64'h0);
    @(negedge clk);
    idle_inputs();
    #2;
    rst = 1'b1;
    cb_if.bus_grant = 4'b1111;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (cb_if.bus_request !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", cb_if.bus_request); end
    n_cmp++; if (cb_if.fu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cb_if.fu_ready); end
    n_cmp++; if (cb_if.bus_en !== 4'b0000) begin n_fail++; $display("FAIL reset_en: got %b want 0000", cb_if.bus_en); end
    n_cmp++; if (cb_if.bus_need !== 2'd0) begin n_fail++; $display("FAIL reset_need: got %0d want 0", cb_if.bus_need); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    $display("reset: count=%0d req=%b ready=%b", count, cb_if.bus_request, cb_if.fu_ready);
  endtask

  task automatic test_single();
    @(negedge clk);
    drive_push(9'h12A, 1'b0, 64'hDEAD, 64'h0);
    #1;
    n_cmp++; if (cb_if.fu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", cb_if.fu_ready); end
    sb.push_back('{tag: 6'h2A, dual: 1'b0, o1: 64'hDEAD, o2: 64'h0});
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (cb_if.bus_request !== 1'b1) begin n_fail++; $display("FAIL single_req: got %b want 1", cb_if.bus_request); end
    n_cmp++; if (cb_if.bus_need !== 2'd1) begin n_fail++; $display("FAIL single_need: got %0d want 1", cb_if.bus_need); end
    cb_if.bus_grant = 4'b0110;
    #1;
    e = sb.pop_front();
    e_en = f_en(cb_if.bus_grant, e.dual, 1'b0); e_sec = f_en(cb_if.bus_grant, e.dual, 1'b1);
    e_tag = f_tag(e_en, e.tag); e_data = f_data(e_en, e_sec, e.o1, e.o2);
    n_cmp++; if (cb_if.bus_en !== e_en) begin n_fail++; $display("FAIL single_en: got %b want %b", cb_if.bus_en, e_en); end
    n_cmp++; if (cb_if.bus_sec !== e_sec) begin n_fail++; $display("FAIL single_sec: got %b want %b", cb_if.bus_sec, e_sec); end
    n_cmp++; if (cb_if.bus_tag !== e_tag) begin n_fail++; $display("FAIL single_tag: got %h want %h", cb_if.bus_tag, e_tag); end
    n_cmp++; if (cb_if.bus_data !== e_data) begin n_fail++; $display("FAIL single_data: got %h want %h", cb_if.bus_data, e_data); end
    $display("single: en=%b tag=%h", cb_if.bus_en, cb_if.bus_tag);
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", count); end
  endtask

  task automatic test_dual();
    @(negedge clk);
    drive_push(9'h1C5, 1'b1, 64'd1, 64'd2);
    sb.push_back('{tag: 6'h05, dual: 1'b1, o1: 64'd1, o2: 64'd2});
    @(negedge clk);
    idle_inputs();
    cb_if.bus_grant = 4'b1000;
    #1;
    n_cmp++; if (cb_if.bus_need !== 2'd2) begin n_fail++; $display("FAIL dual_need: got %0d want 2", cb_if.bus_need); end
    n_cmp++; if (cb_if.bus_en !== 4'b0000) begin n_fail++; $display("FAIL dual_partial_en: got %b want 0000", cb_if.bus_en); end
    @(negedge clk);
    cb_if.bus_grant = 4'b1010;
    #1;
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL dual_nopop_count: got %0d want 1", count); end
    e = sb.pop_front();
    e_en = f_en(cb_if.bus_grant, e.dual, 1'b0); e_sec = f_en(cb_if.bus_grant, e.dual, 1'b1);
    e_tag = f_tag(e_en, e.tag); e_data = f_data(e_en, e_sec, e.o1, e.o2);
    n_cmp++; if (cb_if.bus_en !== e_en) begin n_fail++; $display("FAIL dual_en: got %b want %b", cb_if.bus_en, e_en); end
    n_cmp++; if (cb_if.bus_sec !== e_sec) begin n_fail++; $display("FAIL dual_sec: got %b want %b", cb_if.bus_sec, e_sec); end
    n_cmp++; if (cb_if.bus_tag !== e_tag) begin n_fail++; $display("FAIL dual_tag: got %h want %h", cb_if.bus_tag, e_tag); end
    n_cmp++; if (cb_if.bus_data !== e_data) begin n_fail++; $display("FAIL dual_data: got %h want %h", cb_if.bus_data, e_data); end
    $display("dual: en=%b sec=%b", cb_if.bus_en, cb_if.bus_sec);
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL dual_count: got %0d want 0", count); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle_inputs();
      drive_push(9'h010 + 9'(k), 1'b0, 64'h100 + 64'(k), 64'h0);
      if (k == 4) cb_if.bus_grant = 4'b1111;
      #1;
      n_cmp++;
      if (cb_if.fu_ready !== (k < 4)) begin
        n_fail++; $display("FAIL fill_ready%0d: got %b want %b", k, cb_if.fu_ready, (k < 4));
      end
      if (k < 4) sb.push_back('{tag: 6'h10 + 6'(k), dual: 1'b0, o1: 64'h100 + 64'(k), o2: 64'h0});
      else begin
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
        e = sb.pop_front();
        e_en = f_en(cb_if.bus_grant, e.dual, 1'b0);
        e_data = f_data(e_en, 4'b0000, e.o1, e.o2);
        n_cmp++; if (cb_if.bus_en !== e_en) begin n_fail++; $display("FAIL fill_full_en: got %b want %b", cb_if.bus_en, e_en); end
        n_cmp++; if (cb_if.bus_data !== e_data) begin n_fail++; $display("FAIL fill_full_data: got %h want %h", cb_if.bus_data, e_data); end
      end
      $display("fill: push %0d ready=%b count=%0d", k, cb_if.fu_ready, count);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL fill_after_count: got %0d want 3", count); end
    for (int t = 0; t < 8 && sb.size() > 0; t++) begin
      @(negedge clk);
      cb_if.bus_grant = 4'b0001;
      #1;
      e = sb.pop_front();
      e_en = f_en(cb_if.bus_grant, e.dual, 1'b0);
      e_tag = f_tag(e_en, e.tag); e_data = f_data(e_en, 4'b0000, e.o1, e.o2);
      n_cmp++; if (cb_if.bus_tag !== e_tag) begin n_fail++; $display("FAIL fill_drain_tag: got %h want %h", cb_if.bus_tag, e_tag); end
      n_cmp++; if (cb_if.bus_data !== e_data) begin n_fail++; $display("FAIL fill_drain_data: got %h want %h", cb_if.bus_data, e_data); end
      $display("fill drain: tag=%h", cb_if.bus_tag[5:0]);
    end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL fill_drain_left: got %0d want 0", sb.size()); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL fill_empty: got %0d want 0", count); end
  endtask

  task automatic test_kill();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_push(9'h030 + 9'(k), 1'b0, 64'h300 + 64'(k), 64'h0);
    end
    @(negedge clk);
    drive_push(9'h033, 1'b0, 64'h333, 64'h0);
    kill = 1'b1;
    cb_if.bus_grant = 4'b1111;
    #1;
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL kill_pre_count: got %0d want 3", count); end
    n_cmp++; if (cb_if.bus_en !== 4'b0000) begin n_fail++; $display("FAIL kill_en: got %b want 0000", cb_if.bus_en); end
    n_cmp++; if (cb_if.bus_sec !== 4'b0000) begin n_fail++; $display("FAIL kill_sec: got %b want 0000", cb_if.bus_sec); end
    n_cmp++; if (cb_if.fu_ready !== 1'b1) begin n_fail++; $display("FAIL kill_ready: got %b want 1", cb_if.fu_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL kill_count: got %0d want 0", count); end
    n_cmp++; if (cb_if.bus_request !== 1'b0) begin n_fail++; $display("FAIL kill_req: got %b want 0", cb_if.bus_request); end
    $display("kill: count=%0d req=%b", count, cb_if.bus_request);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_push(9'h040 + 9'(k), 1'b0, 64'h400 + 64'(k), 64'h0);
      sb.push_back('{tag: 6'h00 + 6'(k), dual: 1'b0, o1: 64'h400 + 64'(k), o2: 64'h0});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i < 8) drive_push(9'h042 + 9'(i), 1'b0, 64'h402 + 64'(i), 64'h0);
      cb_if.bus_grant = 4'b0001;
      #1;
      n_cmp++;
      if (count !== 3'(2 - (i > 8 ? 1 : 0))) begin
        n_fail++; $display("FAIL b2b_count%0d: got %0d want %0d", i, count, 2 - (i > 8 ? 1 : 0));
      end
      e = sb.pop_front();
      e_en = f_en(cb_if.bus_grant, e.dual, 1'b0);
      e_tag = f_tag(e_en, e.tag);
      n_cmp++; if (cb_if.bus_tag !== e_tag) begin n_fail++; $display("FAIL b2b_tag%0d: got %h want %h", i, cb_if.bus_tag, e_tag); end
      if (i < 8) sb.push_back('{tag: 6'h02 + 6'(i), dual: 1'b0, o1: 64'h402 + 64'(i), o2: 64'h0});
      $display("b2b: cycle %0d count=%0d tag=%h", i, count, cb_if.bus_tag[5:0]);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_end_count: got %0d want 0", count); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_dual();
    test_fill();
    test_kill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/completion_buffer_q.md
Name: completion_buffer_q

Overview:
- Parametrised completion buffer between one functional unit (FU) and the multi-channel common data bus (CDB).
- Queues FU results (single or dual result per instruction) in a DEPTH-entry FIFO.
- Requests CDB channels, drives granted channels with tag and data, and flushes on kill.
- Successor to the fixed 4-entry, 4-bus completion buffer. Adds backpressure, per-entry dual-result support, channel-count-aware grant handling and occupancy reporting.

Parameters:
- DATA_W, 64, width of each result.
- TAG_W, 6, CDB tag width; taken from inst_tag[TAG_W-1:0].
- ITAG_W, 9, FU instruction tag width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- NBUS, 4, CDB channel count, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- kill  in  1  synchronous flush
- fu_valid  in  1  result presented this cycle
- fu_dual  in  1  entry carries two results
- fu_output1  in  DATA_W  first result
- fu_output2  in  DATA_W  second result; ignored when fu_dual=0
- inst_tag  in  ITAG_W  instruction tag
- fu_ready  out  1  buffer accepts a push
- bus_request  out  1  head entry wants the CDB
- bus_need  out  2  channels needed by head: 0, 1 or 2
- bus_grant  in  NBUS  channels granted to this buffer this cycle
- bus_en  out  NBUS  channel driven this cycle
- bus_sec  out  NBUS  channel carries the second result
- bus_tag  out  TAG_W*NBUS  per-channel tag, channel i at [i*TAG_W +: TAG_W]
- bus_data  out  DATA_W*NBUS  per-channel data
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst=1): rd_ptr=0, wr_ptr=0, count=0, storage contents don't-care. All outputs read 0 except fu_ready=1.
- Push: fu_valid && fu_ready at a rising edge writes {fu_output1, fu_output2, inst_tag, fu_dual} at wr_ptr. wr_ptr then increments modulo DEPTH.
- fu_ready = (count != DEPTH), decoded from registered count only. A full buffer refuses a push even in a cycle where it pops (no pass-through).
- bus_request = (count != 0).
- bus_need = 0 when empty, else 1 + head.dual.
- bus_request and bus_need depend only on registered state. The arbiter sees them one cycle before it grants.
- Grant rule, combinational in the same cycle:
  - c0 = lowest set bit of bus_grant, c1 = next-lowest set bit.
  - If empty, or popcount(bus_grant) < bus_need: bus_en=0, no pop. Partial grants are never used.
  - Else drive c0 with head.out1, tag=head.tag[TAG_W-1:0], bus_sec[c0]=0.
  - If dual, also drive c1 with head.out2, same tag, bus_sec[c1]=1.
  - Pop at the edge: rd_ptr increments modulo DEPTH.
  - Granted channels beyond those needed stay undriven (bus_en=0).
- Undriven channels output tag=0 and data=0.
- Latency: a push at edge N gives bus_request=1 in cycle N+1. A grant in cycle N+1 drives the bus in cycle N+1. Minimum push-to-CDB latency is 1 cycle.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer compare.
- Kill, which has priority over everything:
  - While kill=1: bus_en=0 and bus_sec=0 combinationally, no pop, the push is discarded.
  - At the edge: rd_ptr=wr_ptr=0, count=0.
  - fu_ready stays as decoded from count during the kill cycle; any push accepted is discarded.
- rst asserted mid-transfer clears state immediately, with no bus_en glitch beyond the async clear.

Decomposition:
- Package cb_pkg holds:
  - default widths DATA_W, TAG_W, ITAG_W;
  - entry typedef cb_entry_t {out1, out2, tag, dual};
  - CB_NEED_W=2.
- Sub-module cb_pick2 (NBUS parameter): from bus_grant, outputs one-hot c0 and c1 and a 2-bit saturated popcount (0, 1, 2+). It is purely combinational.
- Storage and pointers stay in the top module.

Test Plan:
- Reset then idle, DEPTH=4, NBUS=4: rst pulse mid-cycle -> count=0, bus_request=0, fu_ready=1, bus_en=0000 asynchronously.
- Single push, tag 9'h12A, out1=64'hDEAD: push at edge N -> cycle N+1 bus_request=1, bus_need=1. bus_grant=0110 -> bus_en=0010, bus_tag ch1=6'h2A, data ch1=64'hDEAD, bus_sec=0000, count=0 next cycle.
- Dual entry, out1=1, out2=2, bus_grant=1000 then 1010 -> first cycle bus_en=0000, no pop. Second cycle ch1 has data 1 with sec=0, ch3 has data 2 with sec=1, then pop.
- Fill: 5 consecutive pushes, no grant -> 4 accepted, fu_ready=0 after the 4th, count=4. The 5th is held off even when a grant arrives in the same cycle. Entries pop in FIFO order across the pointer wrap.
- Kill with count=3 and bus_grant=1111 and fu_valid=1 in the same cycle -> bus_en=0000 that cycle, count=0 next cycle, the push is discarded.
- Simultaneous push and pop at count=2 for 8 cycles -> count stays 2 and output tag order matches input order.
